// File: rtl/mod_div_unit_if.sv
// mod_div_unit_if: start/busy/done handshake bundle for the divide/modulo unit.
// master drives start, A, B; slave (the divider) drives busy, done, quotient, result, b_less, dbz.
// A and B are only looked at by the divider on an accepted start, so the master may change them freely afterwards.
interface mod_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] result;
  logic             b_less;
  logic             dbz;

  modport master (
    output start, A, B,
    input  busy, done, quotient, result, b_less, dbz
  );

  modport slave (
    input  start, A, B,
    output busy, done, quotient, result, b_less, dbz
  );
endinterface

// File: rtl/mod_div_unit.sv
// mod_div_unit: unsigned A / B and A mod B by restoring shift-subtract division, one quotient bit per clock.
// Latency: done WIDTH+1 clocks after accept (2 clocks for divide-by-zero); throughput one op per WIDTH+2 (dbz: 3).
// Backpressure: none queued -- start is only sampled in IDLE; starts while busy or in the done cycle are dropped.
//
// Ports: clk, rst_n (synchronous, active-low), bus (mod_div_unit_if.slave):
//   start/A/B in; busy, done, quotient, result, b_less, dbz out. All outputs decode
//   straight from flops, so there is no combinational path from start/A/B.
module mod_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Working registers
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   rem_reg;    // one guard bit above the remainder
  logic [WIDTH-1:0] q_reg;      // dividend shifts out of the top while quotient bits shift in
  logic [CNT_W-1:0] cnt;
  logic             zero_div;   // operation in flight is a divide-by-zero
  logic             a_lt_b;     // A < B captured at accept

  // Published results; only written on the edge that enters FIN
  logic [WIDTH-1:0] quot_out;
  logic [WIDTH-1:0] rem_out;
  logic             b_less_out;
  logic             dbz_out;

  // One restoring step
  logic [WIDTH:0]   t;
  logic             take;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic             last_iter;
  logic             accept;

  always_comb begin
    t        = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    take     = (t >= {1'b0, b_reg});
    rem_step = take ? (t - {1'b0, b_reg}) : t;
    q_step   = {q_reg[WIDTH-2:0], take};
  end

  assign last_iter = (cnt == CNT_W'(1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. A divide-by-zero still passes through CALC for a single
  // cycle (cnt=1) with the arithmetic frozen, which yields the required
  // 2-clock latency and 3-clock repeat without a dedicated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      q_reg      <= '0;
      cnt        <= '0;
      zero_div   <= 1'b0;
      a_lt_b     <= 1'b0;
      quot_out   <= '0;
      rem_out    <= '0;
      b_less_out <= 1'b0;
      dbz_out    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg    <= bus.A;
        b_reg    <= bus.B;
        rem_reg  <= '0;
        q_reg    <= bus.A;
        zero_div <= (bus.B == '0);
        a_lt_b   <= (bus.A < bus.B);
        cnt      <= (bus.B == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (!zero_div) begin
          rem_reg <= rem_step;
          q_reg   <= q_step;
        end
        // Flags and results become visible together with done, so the
        // outputs describe one completed operation at all times.
        if (last_iter) begin
          b_less_out <= a_lt_b;
          dbz_out    <= zero_div;
          if (zero_div) begin
            quot_out <= '1;
            rem_out  <= a_reg;
          end else begin
            quot_out <= q_step;
            rem_out  <= rem_step[WIDTH-1:0];
          end
        end
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.quotient = quot_out;
  assign bus.result   = rem_out;
  assign bus.b_less   = b_less_out;
  assign bus.dbz      = dbz_out;

endmodule
